alu_req_arbiter: RTL and testbench
==================================

Name: alu_req_arbiter

Overview:
Sequencing controller and two-port arbiter in front of the shared combinational 32-bit ALU (two 16-bit lanes). It accepts operations from two requesters (port 0: core execute stage, port 1: DMA/test master) over valid/ready handshakes, arbitrates them round-robin, and drives the ALU operand and select lines from registers. It waits an op-dependent settle time, then returns result, zero flag and error flag on a per-port response handshake.

Parameters:
MUL_WAIT, 4, settle cycles for select[3:0]==0 (MUL); legal range 1..15.
OP_WAIT, 1, settle cycles for all other legal ops; legal range 1..15.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid / req1_valid  in  1  request present
req0_ready / req1_ready  out  1  request accepted when valid&&ready
req0_a, req0_b / req1_a, req1_b  in  32  operands
req0_sel / req1_sel  in  5  ALU select: [3:0] opcode, [4] mode
rsp0_valid / rsp1_valid  out  1  response present
rsp0_ready / rsp1_ready  in  1  response consumed when valid&&ready
rsp0_data / rsp1_data  out  32  result
rsp0_zero / rsp1_zero  out  1  result == 0
rsp0_err / rsp1_err  out  1  illegal opcode
alu_a, alu_b  out  32  registered ALU operands
alu_sel  out  5  registered ALU select
alu_out  in  32  ALU result
alu_zero  in  1  ALU zero flag
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; alu_a/alu_b=0, alu_sel=0; all rsp*_valid/data/zero/err=0; busy=0; round-robin pointer=port 0. An in-flight operation is dropped without response.
- Legal opcodes (select[3:0]): 0 MUL, 1 ADD/SUB (select[4]=1 subtract), 2 logical shift, 3 arithmetic shift, 5 compare-less, 9 OR, 11 NOR. All others are illegal.
- FSM: IDLE -> WAIT -> RESP -> IDLE; IDLE -> RESP directly for illegal ops.
- IDLE: grant = pointer port if its valid is high, else the other port if valid. reqN_ready = (state==IDLE) && grant==N, combinational; at most one ready high. On handshake at cycle T: latch a/b/sel into alu_a/alu_b/alu_sel (valid T+1); load counter with MUL_WAIT or OP_WAIT.
- WAIT: counter decrements each cycle. At the last count, rsp_data<=alu_out, rsp_zero<=alu_zero, rsp_err<=0. rspN_valid rises at T+1+WAIT.
- Illegal op: alu_* are not updated; RESP at T+1 with data=0, zero=0, err=1.
- RESP: only the granted port's rsp_valid is high; data/zero/err are held stable until handshake. On rspN_ready, return to IDLE and set pointer to the other port. The next request is acceptable the cycle after the response handshake, giving a minimum issue interval of WAIT+2 cycles.
- Simultaneous requests are resolved by the pointer. A port requesting alone is served repeatedly; the pointer does not block it.
- Requesters must hold valid and operands stable until ready. The arbiter samples operands only on the handshake cycle.
- alu_* retain their last issued values between operations.
- The ALU is instantiated by the parent; this block adds no combinational path from alu_out to any output.

Decomposition:
- Package alu_ctrl_pkg: state encoding (IDLE, WAIT, RESP), opcode constants (OP_MUL=0, OP_ADDSUB=1, OP_LSH=2, OP_ASH=3, OP_LESS=5, OP_OR=9, OP_NOR=11), function is_legal_op(sel[3:0]), and function op_wait(sel) returning the settle cycles.
- Sub-module rr_arb2: 2-way round-robin grant with pointer update on a completion strobe.

Test Plan:
- Port 0 only, a=32'h0001_0002, b=32'h0003_0004, sel=5'h01, OP_WAIT=1 -> req0_ready at T, rsp0_valid at T+2, data=32'h0004_0006, zero=0, err=0.
- Port 1, sel=5'h00 (MUL), MUL_WAIT=4 -> rsp1_valid first at T+5; no earlier valid; busy high from T+1 through the handshake.
- Both ports valid in the same cycle after reset -> port 0 granted first; after its response, port 1 granted; pointer returns to 0; second pair of simultaneous requests is served 0 then 1.
- Port 0, sel=5'h07 -> rsp0_valid at T+1, data=0, zero=0, err=1; alu_sel unchanged.
- Port 0, a=b=0, sel=5'h09 (OR) -> data=0, zero=1. Hold rsp0_ready=0 for 5 cycles -> outputs stable, req1_ready stays 0.
- Assert rst_n=0 during WAIT of a MUL -> all outputs zero immediately; after release, a new request completes normally with no stale response.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// ============================================================================
// Module      : alu_ctrl_pkg
// Description : Shared types, opcode constants and helper functions for the
//               ALU request arbiter (FSM state encoding, opcode legality and
//               per-opcode settle time).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_ctrl_pkg;

  // Controller states; explicit 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // ALU opcodes carried in select[3:0].
  localparam logic [3:0] OP_MUL    = 4'd0;
  localparam logic [3:0] OP_ADDSUB = 4'd1;
  localparam logic [3:0] OP_LSH    = 4'd2;
  localparam logic [3:0] OP_ASH    = 4'd3;
  localparam logic [3:0] OP_LESS   = 4'd5;
  localparam logic [3:0] OP_OR     = 4'd9;
  localparam logic [3:0] OP_NOR    = 4'd11;

  // True when the opcode is one the ALU implements.
  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_MUL, OP_ADDSUB, OP_LSH, OP_ASH,
      OP_LESS, OP_OR, OP_NOR: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  // Settle cycles required by an opcode: MUL is the slow path.
  function automatic logic [3:0] op_wait(input logic [3:0] op,
                                         input int unsigned mul_cycles,
                                         input int unsigned other_cycles);
    if (op == OP_MUL) return 4'(mul_cycles);
    else              return 4'(other_cycles);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_req_arbiter_rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin grant. The pointer names the preferred
//               port; it moves to the other port when a served request
//               completes.
// Ports       : clk, rst_n       - clock / async active-low reset
//               req[1:0]         - request lines
//               cpl, cpl_port    - completion strobe and the port it served
//               gnt_valid        - some request is granted
//               gnt_port         - granted port index
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       cpl,
  input  logic       cpl_port,
  output logic       gnt_valid,
  output logic       gnt_port
);

  logic r_ptr;

  // Preferred port wins if requesting; otherwise a lone requester is served
  // regardless of the pointer.
  always_comb begin
    gnt_valid = |req;
    gnt_port  = r_ptr;
    if (!req[r_ptr]) gnt_port = ~r_ptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_ptr <= 1'b0;
    else if (cpl) r_ptr <= ~cpl_port;
  end

endmodule

`default_nettype wire

// File: rtl/alu_req_arbiter.sv
// ============================================================================
// Module      : alu_req_arbiter
// Description : Sequencer and two-port round-robin arbiter in front of a
//               shared combinational ALU. Accepts one operation at a time,
//               drives registered ALU operands/select, waits an op-dependent
//               settle time and returns result/zero/error to the requester.
// Ports       : clk, rst_n                 - clock / async active-low reset
//               reqN_valid/ready/a/b/sel   - request handshake, port N
//               rspN_valid/ready/data/zero/err - response handshake, port N
//               alu_a, alu_b, alu_sel      - registered ALU inputs
//               alu_out, alu_zero          - ALU result
//               busy                       - controller not idle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_req_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned MUL_WAIT = 4,
  parameter int unsigned OP_WAIT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [4:0]  req0_sel,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [4:0]  req1_sel,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_data,
  output logic        rsp0_zero,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_data,
  output logic        rsp1_zero,
  output logic        rsp1_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_sel,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  output logic        busy
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_port;        // port currently being served
  logic [3:0]  r_cnt;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [4:0]  r_alu_sel;
  logic [31:0] r_rsp_data;
  logic        r_rsp_zero;
  logic        r_rsp_err;

  logic        w_gnt_valid;
  logic        w_gnt_port;
  logic        w_accept;
  logic        w_legal;
  logic        w_last;
  logic        w_rsp_ready;
  logic        w_done;
  logic [31:0] w_in_a;
  logic [31:0] w_in_b;
  logic [4:0]  w_in_sel;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       ({req1_valid, req0_valid}),
    .cpl       (w_done),
    .cpl_port  (r_port),
    .gnt_valid (w_gnt_valid),
    .gnt_port  (w_gnt_port)
  );

  assign w_accept    = (r_state == ST_IDLE) && w_gnt_valid;
  assign req0_ready  = w_accept && !w_gnt_port;
  assign req1_ready  = w_accept &&  w_gnt_port;

  assign w_in_a      = w_gnt_port ? req1_a   : req0_a;
  assign w_in_b      = w_gnt_port ? req1_b   : req0_b;
  assign w_in_sel    = w_gnt_port ? req1_sel : req0_sel;
  assign w_legal     = is_legal_op(w_in_sel[3:0]);

  assign w_last      = (r_state == ST_WAIT) && (r_cnt == 4'd1);
  assign w_rsp_ready = r_port ? rsp1_ready : rsp0_ready;
  assign w_done      = (r_state == ST_RESP) && w_rsp_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_legal ? ST_WAIT : ST_RESP;
      ST_WAIT: if (w_last)   w_state_nxt = ST_RESP;
      ST_RESP: if (w_done)   w_state_nxt = ST_IDLE;
      default:               w_state_nxt = ST_IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_port     <= 1'b0;
      r_cnt      <= 4'd0;
      r_alu_a    <= 32'd0;
      r_alu_b    <= 32'd0;
      r_alu_sel  <= 5'd0;
      r_rsp_data <= 32'd0;
      r_rsp_zero <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_port <= w_gnt_port;
        if (w_legal) begin
          r_alu_a   <= w_in_a;
          r_alu_b   <= w_in_b;
          r_alu_sel <= w_in_sel;
          r_cnt     <= op_wait(w_in_sel[3:0], MUL_WAIT, OP_WAIT);
        end else begin
          // Illegal op never reaches the ALU; answer with an error at once.
          r_rsp_data <= 32'd0;
          r_rsp_zero <= 1'b0;
          r_rsp_err  <= 1'b1;
        end
      end
      if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
        if (w_last) begin
          r_rsp_data <= alu_out;
          r_rsp_zero <= alu_zero;
          r_rsp_err  <= 1'b0;
        end
      end
    end
  end

  // ------------------------------------------------------------ outputs
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_sel    = r_alu_sel;
  assign busy       = (r_state != ST_IDLE);

  assign rsp0_valid = (r_state == ST_RESP) && !r_port;
  assign rsp1_valid = (r_state == ST_RESP) &&  r_port;
  assign rsp0_data  = r_rsp_data;
  assign rsp1_data  = r_rsp_data;
  assign rsp0_zero  = r_rsp_zero;
  assign rsp1_zero  = r_rsp_zero;
  assign rsp0_err   = r_rsp_err;
  assign rsp1_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_alu_req_arbiter.sv
// ============================================================================
// Module      : tb_alu_req_arbiter
// Description : Directed self-checking bench for alu_req_arbiter, with a
//               small behavioural ALU standing in for the parent's ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_req_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [4:0]  req0_sel = '0, req1_sel = '0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp0_data, rsp1_data;
  logic        rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [4:0]  alu_sel;
  logic        alu_zero;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_req_arbiter #(.MUL_WAIT(4), .OP_WAIT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_data(rsp0_data), .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_data(rsp1_data), .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .busy(busy)
  );

  // Stand-in ALU (only the ops exercised here need to be meaningful).
  always_comb begin
    case (alu_sel[3:0])
      4'd0:    alu_out = alu_a * alu_b;
      4'd1:    alu_out = alu_sel[4] ? (alu_a - alu_b) : (alu_a + alu_b);
      4'd9:    alu_out = alu_a | alu_b;
      4'd11:   alu_out = ~(alu_a | alu_b);
      default: alu_out = alu_a ^ alu_b;
    endcase
    alu_zero = (alu_out == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request at the current cycle; it must be accepted this cycle.
  task automatic issue(input int p, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] s, input string tag);
    if (p == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = s;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = s;
    end
    #1;
    check({tag, "_ready"},   {31'd0, (p == 0) ? req0_ready : req1_ready}, 32'd1);
    check({tag, "_noready"}, {31'd0, (p == 0) ? req1_ready : req0_ready}, 32'd0);
    @(posedge clk);
    #1;
    if (p == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  // Called at T+1; counts cycles from handshake T until rspN_valid.
  task automatic wait_rsp(input int p, input int exp_lat, input string tag);
    int n = 1;
    while (((p == 0) ? rsp0_valid : rsp1_valid) !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    check({tag, "_latency"}, n, exp_lat);
  endtask

  task automatic respond(input int p, input string tag);
    if (p == 0) rsp0_ready = 1'b1;
    else        rsp1_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    check({tag, "_rsp_drop"}, {31'd0, (p == 0) ? rsp0_valid : rsp1_valid}, 32'd0);
    check({tag, "_idle"},     {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // ---------------- reset state
    step(); step();
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_alu_a",  alu_a, 32'd0);
    check("rst_alu_sel",{27'd0, alu_sel}, 32'd0);
    check("rst_rsp0_v", {31'd0, rsp0_valid}, 32'd0);
    check("rst_rsp1_v", {31'd0, rsp1_valid}, 32'd0);
    rst_n = 1'b1;
    step();

    // ---------------- port 0 ADD, OP_WAIT=1
    issue(0, 32'h0001_0002, 32'h0003_0004, 5'h01, "add");
    check("add_busy_t1", {31'd0, busy}, 32'd1);
    check("add_alu_a",   alu_a, 32'h0001_0002);
    check("add_alu_b",   alu_b, 32'h0003_0004);
    check("add_alu_sel", {27'd0, alu_sel}, 32'h01);
    wait_rsp(0, 2, "add");
    check("add_data", rsp0_data, 32'h0004_0006);
    check("add_zero", {31'd0, rsp0_zero}, 32'd0);
    check("add_err",  {31'd0, rsp0_err}, 32'd0);
    check("add_rsp1", {31'd0, rsp1_valid}, 32'd0);
    respond(0, "add");

    // ---------------- port 1 MUL, MUL_WAIT=4
    issue(1, 32'd6, 32'd7, 5'h00, "mul");
    check("mul_busy_t1", {31'd0, busy}, 32'd1);
    wait_rsp(1, 5, "mul");
    check("mul_data", rsp1_data, 32'd42);
    check("mul_busy_rsp", {31'd0, busy}, 32'd1);
    check("mul_rsp0", {31'd0, rsp0_valid}, 32'd0);
    respond(1, "mul");

    // ---------------- simultaneous requests, two rounds
    for (int r = 0; r < 2; r++) begin
      req1_valid = 1'b1; req1_a = 32'h0000_00F0; req1_b = 32'h0000_000F; req1_sel = 5'h09;
      issue(0, 32'd5, 32'd3, 5'h11, "both_p0");
      check("both_p1_held", {31'd0, req1_ready}, 32'd0);
      wait_rsp(0, 2, "both_p0");
      check("both_sub_data", rsp0_data, 32'd2);
      respond(0, "both_p0");
      // Port 1 has been waiting and now owns the pointer.
      check("both_p1_ready", {31'd0, req1_ready}, 32'd1);
      check("both_p0_nordy", {31'd0, req0_ready}, 32'd0);
      step();
      req1_valid = 1'b0;
      wait_rsp(1, 2, "both_p1");
      check("both_or_data", rsp1_data, 32'h0000_00FF);
      respond(1, "both_p1");
    end

    // ---------------- illegal opcode
    issue(0, 32'h1234_5678, 32'h1, 5'h07, "ill");
    wait_rsp(0, 1, "ill");
    check("ill_data", rsp0_data, 32'd0);
    check("ill_zero", {31'd0, rsp0_zero}, 32'd0);
    check("ill_err",  {31'd0, rsp0_err}, 32'd1);
    check("ill_alu_sel", {27'd0, alu_sel}, 32'h09);
    check("ill_alu_a",   alu_a, 32'h0000_00F0);
    respond(0, "ill");

    // ---------------- zero result with response back-pressure
    issue(0, 32'd0, 32'd0, 5'h09, "zero");
    wait_rsp(0, 2, "zero");
    req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd1; req1_sel = 5'h01;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", {31'd0, rsp0_valid}, 32'd1);
      check("hold_data",  rsp0_data, 32'd0);
      check("hold_zero",  {31'd0, rsp0_zero}, 32'd1);
      check("hold_err",   {31'd0, rsp0_err}, 32'd0);
      check("hold_r1rdy", {31'd0, req1_ready}, 32'd0);
    end
    req1_valid = 1'b0;
    respond(0, "zero");

    // ---------------- reset during a MUL wait
    issue(1, 32'd3, 32'd7, 5'h00, "rst_mul");
    step();
    check("rstmul_busy_pre", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",   {31'd0, busy}, 32'd0);
    check("arst_rsp1_v", {31'd0, rsp1_valid}, 32'd0);
    check("arst_alu_a",  alu_a, 32'd0);
    check("arst_alu_b",  alu_b, 32'd0);
    check("arst_alu_sel",{27'd0, alu_sel}, 32'd0);
    check("arst_data",   rsp1_data, 32'd0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("post_rst_no_rsp", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    end
    issue(0, 32'd3, 32'd7, 5'h00, "after_rst");
    wait_rsp(0, 5, "after_rst");
    check("after_rst_data", rsp0_data, 32'd21);
    check("after_rst_rsp1", {31'd0, rsp1_valid}, 32'd0);
    respond(0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
